// File: rtl/switch_pio_servicer_pkg.sv
// Shared definitions for the switch PIO: register addresses, servicer FSM encoding and
// default input width. Used by the servicer, the PIO slave and its bench model.
package switch_pio_servicer_pkg;

  localparam int DEFAULT_WIDTH = 10;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam logic [2:0] ST_WR_MASK   = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_RD_EDGE   = 3'd2;
  localparam logic [2:0] ST_WAIT_EDGE = 3'd3;
  localparam logic [2:0] ST_CLR_EDGE  = 3'd4;
  localparam logic [2:0] ST_RD_LVL    = 3'd5;
  localparam logic [2:0] ST_WAIT_LVL  = 3'd6;
  localparam logic [2:0] ST_PRESENT   = 3'd7;

  // Register each state addresses; the address is held through the read-latency wait.
  function automatic logic [1:0] state_addr(input logic [2:0] st);
    case (st)
      ST_WR_MASK:                           return ADDR_MASK;
      ST_RD_EDGE, ST_WAIT_EDGE, ST_CLR_EDGE: return ADDR_EDGE;
      default:                              return ADDR_DATA;
    endcase
  endfunction

endpackage

// File: rtl/switch_pio_servicer.sv
// Avalon-MM master servicing an edge-capturing input PIO: programs the irq mask, and on irq
// reads/clears the edge capture, reads the level and presents {edges, level} as one event.
module switch_pio_servicer
  import switch_pio_servicer_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  input  logic             pio_irq,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             cfg_load,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_edges,
  output logic [WIDTH-1:0] evt_level,
  output logic             busy
);

  localparam int              CW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0]   LAT_LAST = CW'(RD_LAT - 1);

  logic [2:0]       state, state_nxt;
  logic             run;
  logic [WIDTH-1:0] mask_q;
  logic             load_pend;
  logic [CW-1:0]    lat_cnt;
  logic             in_wait, lat_done;
  logic [WIDTH-1:0] rd_val;
  logic             unused_rd;

  assign rd_val    = avm_readdata[WIDTH-1:0];
  assign unused_rd = ^avm_readdata[31:WIDTH];
  assign in_wait   = (state == ST_WAIT_EDGE) || (state == ST_WAIT_LVL);
  assign lat_done  = (lat_cnt == LAT_LAST);

  always_comb begin
    // NOTE: assign a default before the case so every path drives state_nxt; no latch.
    state_nxt = state;
    case (state)
      ST_WR_MASK:   if (run) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (load_pend || cfg_load) state_nxt = ST_WR_MASK;
        else if (pio_irq)          state_nxt = ST_RD_EDGE;
      end
      ST_RD_EDGE:   state_nxt = ST_WAIT_EDGE;
      ST_WAIT_EDGE: if (lat_done) state_nxt = (rd_val == '0) ? ST_IDLE : ST_CLR_EDGE;
      ST_CLR_EDGE:  state_nxt = ST_RD_LVL;
      ST_RD_LVL:    state_nxt = ST_WAIT_LVL;
      ST_WAIT_LVL:  if (lat_done) state_nxt = ST_PRESENT;
      ST_PRESENT:   if (evt_ready) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // run holds the bus quiet for the first cycle after reset so no strobe is seen during reset.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      state     <= ST_WR_MASK;
      run       <= 1'b0;
      mask_q    <= '1;
      load_pend <= 1'b0;
      lat_cnt   <= '0;
      evt_edges <= '0;
      evt_level <= '0;
    end else begin
      run   <= 1'b1;
      state <= state_nxt;
      if (cfg_load) mask_q <= cfg_mask;
      // IDLE always consumes a pending or same-cycle load by going to WR_MASK.
      if (state == ST_IDLE)  load_pend <= 1'b0;
      else if (cfg_load)     load_pend <= 1'b1;
      if (in_wait && !lat_done) lat_cnt <= lat_cnt + 1'b1;
      else                      lat_cnt <= '0;
      if (state == ST_WAIT_EDGE && lat_done) evt_edges <= rd_val;
      if (state == ST_WAIT_LVL  && lat_done) evt_level <= rd_val;
    end
  end

  assign avm_chipselect = run && (state inside {ST_WR_MASK, ST_RD_EDGE, ST_CLR_EDGE, ST_RD_LVL});
  assign avm_write_n    = !(run && (state inside {ST_WR_MASK, ST_CLR_EDGE}));
  assign avm_address    = run ? state_addr(state) : ADDR_DATA;
  assign avm_writedata  = (run && state == ST_WR_MASK) ? {{(32-WIDTH){1'b0}}, mask_q} : 32'd0;
  assign evt_valid      = (state == ST_PRESENT);
  assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_switch_pio_servicer.sv
// Bench for switch_pio_servicer: PIO slave model with registered readdata (RD_LAT=1) and
// queue-based scoreboards for bus cycles and delivered events.
module tb_switch_pio_servicer;
  import switch_pio_servicer_pkg::*;

  localparam int W = 10;
  localparam logic [31-W:0] JUNK = 22'h2AAAAA;

  typedef struct packed {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] data;
  } bus_t;

  typedef struct packed {
    logic [W-1:0] edges;
    logic [W-1:0] level;
  } evt_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   avm_address;
  logic         avm_chipselect;
  logic         avm_write_n;
  logic [31:0]  avm_writedata;
  logic [31:0]  avm_readdata = '0;
  logic         pio_irq;
  logic [W-1:0] cfg_mask = '0;
  logic         cfg_load = 1'b0;
  logic         evt_valid;
  logic         evt_ready = 1'b0;
  logic [W-1:0] evt_edges;
  logic [W-1:0] evt_level;
  logic         busy;

  int checks = 0;
  int errors = 0;
  bus_t bus_q[$];
  evt_t evt_q[$];

  always #5 clk = ~clk;

  switch_pio_servicer #(.WIDTH(W), .RD_LAT(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .pio_irq(pio_irq),
    .cfg_mask(cfg_mask), .cfg_load(cfg_load),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_edges(evt_edges),
    .evt_level(evt_level), .busy(busy)
  );

  // PIO slave model: rising-edge capture, write to EDGE clears, junk in unused readdata bits.
  logic [W-1:0] in_port = '0, in_prev = '0, pio_mask = '0, edge_cap = '0;
  logic         irq_force = 1'b0, model_clr = 1'b0;

  always @(posedge clk) begin
    in_prev <= in_port;
    if (avm_chipselect && !avm_write_n && avm_address == ADDR_MASK)
      pio_mask <= avm_writedata[W-1:0];
    if (model_clr || (avm_chipselect && !avm_write_n && avm_address == ADDR_EDGE))
      edge_cap <= '0;
    else
      edge_cap <= edge_cap | (in_port & ~in_prev);
    if (avm_chipselect && avm_write_n) begin
      case (avm_address)
        ADDR_DATA: avm_readdata <= {JUNK, in_port};
        ADDR_MASK: avm_readdata <= {JUNK, pio_mask};
        ADDR_EDGE: avm_readdata <= {JUNK, edge_cap};
        default:   avm_readdata <= '0;
      endcase
    end
  end

  assign pio_irq = (|(edge_cap & pio_mask)) | irq_force;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic push_bus(input logic wr, input logic [1:0] addr, input logic [31:0] data);
    bus_t b;
    b.wr = wr; b.addr = addr; b.data = data;
    bus_q.push_back(b);
  endtask

  task automatic push_evt(input logic [W-1:0] edges, input logic [W-1:0] level);
    evt_t e;
    e.edges = edges; e.level = level;
    evt_q.push_back(e);
  endtask

  // Bus and event monitor: compares every strobe and every accepted event against the queues.
  initial begin
    bus_t b;
    evt_t e;
    forever begin
      @(negedge clk);
      if (reset_n && avm_chipselect) begin
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_unexpected: got wr=%0b addr=%0d data=0x%0h expected no cycle",
                   !avm_write_n, avm_address, avm_writedata);
        end else begin
          b = bus_q.pop_front();
          check("bus_wr", {31'd0, !avm_write_n}, {31'd0, b.wr});
          check("bus_addr", {30'd0, avm_address}, {30'd0, b.addr});
          if (b.wr) check("bus_wdata", avm_writedata, b.data);
        end
      end
      if (reset_n && evt_valid && evt_ready) begin
        if (evt_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL evt_unexpected: got edges=0x%0h level=0x%0h expected no event",
                   evt_edges, evt_level);
        end else begin
          e = evt_q.pop_front();
          check("evt_edges", {22'd0, evt_edges}, {22'd0, e.edges});
          check("evt_level", {22'd0, evt_level}, {22'd0, e.level});
        end
      end
    end
  end

  task automatic drain(input string name, input int budget);
    int n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      done = (bus_q.size() == 0) && (evt_q.size() == 0) && !busy;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int busy_cnt;
    logic seen;

    // 1: reset values, then the mask write of all ones.
    #12;
    check("rst_cs", {31'd0, avm_chipselect}, 32'd0);
    check("rst_write_n", {31'd0, avm_write_n}, 32'd1);
    check("rst_addr", {30'd0, avm_address}, 32'd0);
    check("rst_wdata", avm_writedata, 32'd0);
    check("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_evt_edges", {22'd0, evt_edges}, 32'd0);
    check("rst_evt_level", {22'd0, evt_level}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    push_bus(1'b1, ADDR_MASK, 32'h3FF);
    tick();
    reset_n = 1'b1;
    drain("t1_mask_write_idle", 40);

    // 2: single rising edge on bit 3.
    evt_ready = 1'b1;
    push_bus(1'b0, ADDR_EDGE, 32'd0);
    push_bus(1'b1, ADDR_EDGE, 32'd0);
    push_bus(1'b0, ADDR_DATA, 32'd0);
    push_evt(10'h008, 10'h008);
    tick();
    in_port[3] = 1'b1;
    drain("t2_event_done", 60);
    check("t2_irq_cleared", {31'd0, pio_irq}, 32'd0);

    // 3: backpressure; second edge accumulates and becomes the next event.
    evt_ready = 1'b0;
    push_bus(1'b0, ADDR_EDGE, 32'd0);
    push_bus(1'b1, ADDR_EDGE, 32'd0);
    push_bus(1'b0, ADDR_DATA, 32'd0);
    push_evt(10'h001, 10'h009);
    tick();
    in_port[0] = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      seen = evt_valid;
    end
    check("t3_first_valid", {31'd0, seen}, 32'd1);
    tick();
    in_port[5] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_valid", {31'd0, evt_valid}, 32'd1);
      check("t3_hold_edges", {22'd0, evt_edges}, 32'h001);
      check("t3_hold_level", {22'd0, evt_level}, 32'h009);
    end
    push_bus(1'b0, ADDR_EDGE, 32'd0);
    push_bus(1'b1, ADDR_EDGE, 32'd0);
    push_bus(1'b0, ADDR_DATA, 32'd0);
    push_evt(10'h020, 10'h029);
    tick();
    evt_ready = 1'b1;
    drain("t3_both_events", 60);

    // 4: two cfg_load pulses mid-service; the last one wins and is written after the event.
    push_bus(1'b0, ADDR_EDGE, 32'd0);
    push_bus(1'b1, ADDR_EDGE, 32'd0);
    push_bus(1'b0, ADDR_DATA, 32'd0);
    push_evt(10'h002, 10'h02B);
    push_bus(1'b1, ADDR_MASK, 32'h00F);
    tick();
    in_port[1] = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = busy;
    end
    check("t4_service_started", {31'd0, seen}, 32'd1);
    tick();
    cfg_mask = 10'h0F0;
    cfg_load = 1'b1;
    tick();
    cfg_mask = 10'h00F;
    tick();
    cfg_load = 1'b0;
    cfg_mask = 10'h3C3;
    drain("t4_event_and_mask", 60);
    tick();
    in_port[7] = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("t4_masked_no_service", busy_cnt, 32'd0);
    check("t4_masked_irq_low", {31'd0, pio_irq}, 32'd0);

    // 5: spurious irq with empty edge capture: one read, no clear, no event.
    tick();
    model_clr = 1'b1;
    tick();
    model_clr = 1'b0;
    push_bus(1'b0, ADDR_EDGE, 32'd0);
    irq_force = 1'b1;
    tick();
    irq_force = 1'b0;
    drain("t5_spurious_idle", 30);
    repeat (8) @(negedge clk);
    check("t5_still_idle", {31'd0, busy}, 32'd0);

    // 6: reset during WAIT_LVL abandons the transaction and reissues the mask write.
    push_bus(1'b0, ADDR_EDGE, 32'd0);
    push_bus(1'b1, ADDR_EDGE, 32'd0);
    push_bus(1'b0, ADDR_DATA, 32'd0);
    tick();
    in_port[2] = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      seen = avm_chipselect && avm_write_n && (avm_address == ADDR_DATA);
    end
    check("t6_reached_rd_lvl", {31'd0, seen}, 32'd1);
    tick();
    reset_n = 1'b0;
    #1;
    check("t6_rst_cs", {31'd0, avm_chipselect}, 32'd0);
    check("t6_rst_evt_valid", {31'd0, evt_valid}, 32'd0);
    check("t6_rst_evt_edges", {22'd0, evt_edges}, 32'd0);
    check("t6_rst_write_n", {31'd0, avm_write_n}, 32'd1);
    check("t6_rst_busy", {31'd0, busy}, 32'd1);
    repeat (2) tick();
    push_bus(1'b1, ADDR_MASK, 32'h3FF);
    reset_n = 1'b1;
    drain("t6_mask_reissued", 40);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
